// File: rtl/player_pkg.sv
// Shared types and helpers for the player physics block.
// Holds the motion state enum and the fixed-point width rule.
package player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AIR,
    ST_DEAD
  } state_e;

  function automatic int fp_w(input int y_w, input int frac);
    return y_w + frac + 2;
  endfunction

endpackage

// File: rtl/sprite_window.sv
// Registered render window: tests the raster beam against the sprite box
// and produces ROM coordinates, mirrored horizontally when facing left.
module sprite_window #(
  parameter int WIDTH  = 80,
  parameter int HEIGHT = 80,
  parameter int X_W    = 11,
  parameter int Y_W    = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [X_W-1:0]            pos_x,
  input  logic [Y_W-1:0]            pos_y,
  input  logic                      facing_left,
  input  logic [X_W-1:0]            beam_x,
  input  logic [Y_W-1:0]            beam_y,
  output logic                      in_sprite,
  output logic [$clog2(WIDTH)-1:0]  sprite_u,
  output logic [$clog2(HEIGHT)-1:0] sprite_v
);

  localparam int UW = $clog2(WIDTH);
  localparam int VW = $clog2(HEIGHT);
  localparam logic [X_W:0] WX = (X_W+1)'(WIDTH);
  localparam logic [Y_W:0] HY = (Y_W+1)'(HEIGHT);
  localparam logic [UW-1:0] UMAX = UW'(WIDTH - 1);

  logic [X_W:0]  dx;
  logic [Y_W:0]  dy;
  logic          in_d;
  logic [UW-1:0] u_d;
  logic [VW-1:0] v_d;
  logic          in_q;
  logic [UW-1:0] u_q;
  logic [VW-1:0] v_q;

  always_comb begin
    dx   = {1'b0, beam_x} - {1'b0, pos_x};
    dy   = {1'b0, beam_y} - {1'b0, pos_y};
    in_d = (beam_x >= pos_x) && (dx < WX) &&
           (beam_y >= pos_y) && (dy < HY);
    u_d  = facing_left ? (UMAX - dx[UW-1:0]) : dx[UW-1:0];
    v_d  = dy[VW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= 1'b0;
      u_q  <= '0;
      v_q  <= '0;
    end else begin
      in_q <= in_d;
      u_q  <= u_d;
      v_q  <= v_d;
    end
  end

  assign in_sprite = in_q;
  assign sprite_u  = u_q;
  assign sprite_v  = v_q;

endmodule

// File: rtl/player_physics.sv
// Player sprite motion: gravity, landing bounce, scroll clamp, death,
// horizontal wrap, and the registered render window.
import player_pkg::*;

module player_physics #(
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int FRAC        = 4,
  parameter int WIDTH       = 80,
  parameter int HEIGHT      = 80,
  parameter int START_X     = 280,
  parameter int START_Y     = 399,
  parameter int GRAVITY     = 8,
  parameter int JUMP_V      = 160,
  parameter int VMAX        = 256,
  parameter int LEFT_B      = 160,
  parameter int RIGHT_B     = 640,
  parameter int SCROLL_LINE = 200,
  parameter int DEATH_Y     = 480
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      run,
  input  logic signed [8:0]         delta_x,
  input  logic                      land_hit,
  input  logic [Y_W-1:0]            land_y,
  input  logic [X_W-1:0]            beam_x,
  input  logic [Y_W-1:0]            beam_y,
  output logic [X_W-1:0]            pos_x,
  output logic [Y_W-1:0]            pos_y,
  output logic                      falling,
  output logic                      facing_left,
  output logic                      scroll_valid,
  output logic [Y_W-1:0]            scroll_amt,
  output logic                      dead,
  output logic                      in_sprite,
  output logic [$clog2(WIDTH)-1:0]  sprite_u,
  output logic [$clog2(HEIGHT)-1:0] sprite_v
);

  localparam int YF_W = fp_w(Y_W, FRAC);
  localparam int XS_W = X_W + 2;

  typedef logic signed [YF_W-1:0] yfp_t;
  typedef logic signed [XS_W-1:0] xs_t;

  localparam yfp_t ZERO      = '0;
  localparam yfp_t GRAV      = YF_W'(GRAVITY);
  localparam yfp_t JUMP_NEG  = YF_W'(-JUMP_V);
  localparam yfp_t VMAX_S    = YF_W'(VMAX);
  localparam yfp_t HEIGHT_FP = YF_W'(HEIGHT << FRAC);
  localparam yfp_t SCROLL_S  = YF_W'(SCROLL_LINE);
  localparam yfp_t SCROLL_FP = YF_W'(SCROLL_LINE << FRAC);
  localparam yfp_t DEATH_S   = YF_W'(DEATH_Y);
  localparam yfp_t START_FP  = YF_W'(START_Y << FRAC);

  localparam xs_t X_LO = XS_W'(LEFT_B - WIDTH / 2);
  localparam xs_t X_HI = XS_W'(RIGHT_B - WIDTH / 2);
  localparam logic [X_W-1:0] X_TO_R = X_W'(RIGHT_B - WIDTH / 2 - 1);
  localparam logic [X_W-1:0] X_TO_L = X_W'(LEFT_B - WIDTH / 2 + 1);
  localparam logic [X_W-1:0] X_RST  = X_W'(START_X);

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  yfp_t           y_q, y_d;
  yfp_t           vy_q, vy_d;
  logic           face_q, face_d;
  logic           fall_q, fall_d;
  logic           sv_q, sv_d;
  logic [Y_W-1:0] amt_q, amt_d;

  logic           step;
  xs_t            xn;
  logic [X_W-1:0] x_nx;
  logic           face_nx;
  yfp_t           vy_sum, vy_sat, y_sum;
  yfp_t           land_fp, y_res, vy_res, yi, y_fin;
  logic           land, scroll, die;
  logic [Y_W-1:0] amt;

  assign step = frame_tick & run;

  // Candidate next values for one AIR step, landing before scroll/death.
  always_comb begin
    xn = xs_t'({2'b00, x_q}) + xs_t'(delta_x);
    if (xn <= X_LO) begin
      x_nx = X_TO_R;
    end else if (xn >= X_HI) begin
      x_nx = X_TO_L;
    end else begin
      x_nx = xn[X_W-1:0];
    end
    face_nx = delta_x[8] ? 1'b1 :
              (|delta_x) ? 1'b0 : face_q;
    vy_sum  = vy_q + GRAV;
    vy_sat  = (vy_sum > VMAX_S) ? VMAX_S : vy_sum;
    y_sum   = y_q + vy_q;
    land    = land_hit && (vy_q > ZERO);
    land_fp = yfp_t'({2'b00, land_y, {FRAC{1'b0}}}) - HEIGHT_FP;
    y_res   = land ? land_fp : y_sum;
    vy_res  = land ? JUMP_NEG : vy_sat;
    yi      = y_res >>> FRAC;
    scroll  = yi < SCROLL_S;
    y_fin   = scroll ? SCROLL_FP : y_res;
    amt     = Y_W'(SCROLL_S - yi);
    die     = !land && (yi >= DEATH_S);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= X_RST;
      y_q     <= START_FP;
      vy_q    <= ZERO;
      face_q  <= 1'b0;
      fall_q  <= 1'b0;
      sv_q    <= 1'b0;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      face_q  <= face_d;
      fall_q  <= fall_d;
      sv_q    <= sv_d;
      amt_q   <= amt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (step) begin
      unique case (state_q)
        ST_IDLE: state_d = ST_AIR;
        ST_AIR:  if (die) state_d = ST_DEAD;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    vy_d   = vy_q;
    face_d = face_q;
    sv_d   = 1'b0;
    amt_d  = amt_q;
    if (step) begin
      unique case (state_q)
        ST_IDLE: begin
          x_d    = x_nx;
          face_d = face_nx;
          vy_d   = JUMP_NEG;
        end
        ST_AIR: begin
          x_d    = x_nx;
          face_d = face_nx;
          y_d    = y_fin;
          vy_d   = vy_res;
          sv_d   = scroll;
          if (scroll) amt_d = amt;
        end
        default: ;
      endcase
    end
    fall_d = vy_d > ZERO;
  end

  assign pos_x        = x_q;
  assign pos_y        = y_q[FRAC +: Y_W];
  assign falling      = fall_q;
  assign facing_left  = face_q;
  assign scroll_valid = sv_q;
  assign scroll_amt   = amt_q;
  assign dead         = (state_q == ST_DEAD);

  sprite_window #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .pos_x      (x_q),
    .pos_y      (pos_y),
    .facing_left(face_q),
    .beam_x     (beam_x),
    .beam_y     (beam_y),
    .in_sprite  (in_sprite),
    .sprite_u   (sprite_u),
    .sprite_v   (sprite_v)
  );

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics with hand-computed expectations.
module tb_player_physics;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_tick;
  logic              run;
  logic signed [8:0] delta_x;
  logic              land_hit;
  logic [9:0]        land_y;
  logic [10:0]       beam_x;
  logic [9:0]        beam_y;
  logic [10:0]       pos_x;
  logic [9:0]        pos_y;
  logic              falling;
  logic              facing_left;
  logic              scroll_valid;
  logic [9:0]        scroll_amt;
  logic              dead;
  logic              in_sprite;
  logic [6:0]        sprite_u;
  logic [6:0]        sprite_v;

  int nchk = 0;
  int nerr = 0;

  player_physics dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .run         (run),
    .delta_x     (delta_x),
    .land_hit    (land_hit),
    .land_y      (land_y),
    .beam_x      (beam_x),
    .beam_y      (beam_y),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .falling     (falling),
    .facing_left (facing_left),
    .scroll_valid(scroll_valid),
    .scroll_amt  (scroll_amt),
    .dead        (dead),
    .in_sprite   (in_sprite),
    .sprite_u    (sprite_u),
    .sprite_v    (sprite_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int dx);
    @(negedge clk);
    delta_x    = dx[8:0];
    frame_tick = 1'b1;
    run        = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beam(input int bx, input int by);
    @(negedge clk);
    beam_x = bx[10:0];
    beam_y = by[9:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; run = 1'b0;
    delta_x = '0; land_hit = 1'b0; land_y = '0;
    beam_x = '0; beam_y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos_x", pos_x, 280);
    chk("rst_pos_y", pos_y, 399);
    chk("rst_dead", dead, 0);
    chk("rst_falling", falling, 0);
    chk("rst_scroll", scroll_valid, 0);
    chk("rst_amt", scroll_amt, 0);
    chk("rst_face", facing_left, 0);
    chk("rst_in", in_sprite, 0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    frame_tick = 1'b1; run = 1'b0;
    idle_cycle();
    frame_tick = 1'b0;
    chk("frozen_vy", dut.vy_q, 0);
    chk("frozen_y", pos_y, 399);

    step(0);
    chk("idle_step_y", pos_y, 399);
    chk("idle_step_vy", dut.vy_q, -160);
    chk("idle_step_fall", falling, 0);

    land_hit = 1'b1; land_y = 10'd420;
    step(0);
    land_hit = 1'b0;
    chk("air1_y", pos_y, 389);
    chk("air1_vy_rise_land", dut.vy_q, -152);

    repeat (19) step(0);
    chk("apex_y", pos_y, 294);
    chk("apex_vy", dut.vy_q, 0);
    chk("apex_fall", falling, 0);
    step(0);
    chk("fall_start_y", pos_y, 294);
    chk("fall_start_f", falling, 1);

    land_hit = 1'b1; land_y = 10'd420;
    step(0);
    land_hit = 1'b0;
    chk("land_y", pos_y, 340);
    chk("land_vy", dut.vy_q, -160);
    chk("land_fall", falling, 0);

    repeat (21) step(0);
    chk("arc2_y", pos_y, 235);
    chk("arc2_fall", falling, 1);
    land_hit = 1'b1; land_y = 10'd285;
    step(0);
    land_hit = 1'b0;
    chk("land2_y", pos_y, 205);

    step(0);
    chk("scroll_y", pos_y, 200);
    chk("scroll_v", scroll_valid, 1);
    chk("scroll_amt", scroll_amt, 5);
    idle_cycle();
    chk("scroll_pulse", scroll_valid, 0);

    repeat (19) step(0);
    chk("clamp_y", pos_y, 200);
    chk("clamp_vy", dut.vy_q, 0);
    chk("clamp_amt", scroll_amt, 1);

    repeat (32) step(0);
    chk("sat_vy", dut.vy_q, 256);
    chk("sat_y", pos_y, 448);
    chk("sat_alive", dead, 0);
    step(0);
    chk("term_y", pos_y, 464);
    chk("term_vy", dut.vy_q, 256);
    step(0);
    chk("death", dead, 1);
    chk("death_y", pos_y, 480);
    step(5);
    chk("dead_hold_x", pos_x, 280);
    chk("dead_hold_y", pos_y, 480);
    chk("dead_stays", dead, 1);

    @(negedge clk);
    rst = 1'b1; frame_tick = 1'b1; run = 1'b1;
    idle_cycle();
    rst = 1'b0; frame_tick = 1'b0;
    chk("rst2_x", pos_x, 280);
    chk("rst2_y", pos_y, 399);
    chk("rst2_dead", dead, 0);
    chk("rst2_vy", dut.vy_q, 0);

    step(-159);
    chk("hx_121", pos_x, 121);
    chk("hx_face_l", facing_left, 1);
    step(-1);
    chk("hx_wrap_l", pos_x, 599);
    step(1);
    chk("hx_wrap_r", pos_x, 121);
    chk("hx_face_r", facing_left, 0);
    step(159);
    chk("hx_280", pos_x, 280);
    step(-3);
    chk("hx_277", pos_x, 277);
    chk("hx_face3", facing_left, 1);
    step(0);
    chk("hx_hold_x", pos_x, 277);
    chk("hx_hold_face", facing_left, 1);
    chk("hx_y", pos_y, 354);

    beam(277, 354);
    chk("win_tl_in", in_sprite, 1);
    chk("win_tl_u", sprite_u, 79);
    chk("win_tl_v", sprite_v, 0);
    beam(356, 433);
    chk("win_br_in", in_sprite, 1);
    chk("win_br_u", sprite_u, 0);
    chk("win_br_v", sprite_v, 79);
    beam(357, 400);
    chk("win_right_out", in_sprite, 0);
    beam(300, 353);
    chk("win_top_out", in_sprite, 0);
    beam(276, 400);
    chk("win_left_out", in_sprite, 0);

    step(1);
    chk("hx_278", pos_x, 278);
    chk("hy_346", pos_y, 346);
    beam(288, 356);
    chk("win_r_in", in_sprite, 1);
    chk("win_r_u", sprite_u, 10);
    chk("win_r_v", sprite_v, 10);
    beam(300, 426);
    chk("win_bot_out", in_sprite, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/player_physics.md
PLAYER_PHYSICS -- requirements
Module: player_physics

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- X_W, 11, horizontal coordinate width
- Y_W, 10, vertical coordinate width
- FRAC, 4, fractional bits of the vertical fixed point
- WIDTH, 80, sprite width in px
- HEIGHT, 80, sprite height in px
- START_X, 280, reset x
- START_Y, 399, reset y
- GRAVITY, 8, velocity increment per tick, in 1/2^FRAC px
- JUMP_V, 160, jump speed magnitude, in 1/2^FRAC px
- VMAX, 256, terminal fall speed, in 1/2^FRAC px
- LEFT_B, 160, playfield left border x
- RIGHT_B, 640, playfield right border x
- SCROLL_LINE, 200, highest allowed sprite top y
- DEATH_Y, 480, sprite-top y that kills
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- frame_tick, in, 1, one-cycle physics step strobe
- run, in, 1, game active; low freezes physics
- delta_x, in, 9 signed, horizontal step per tick
- land_hit, in, 1, sprite feet overlap a platform top
- land_y, in, Y_W, that platform's top y
- beam_x, in, X_W, raster x
- beam_y, in, Y_W, raster y
- pos_x, out, X_W, sprite left x
- pos_y, out, Y_W, sprite top y (integer part)
- falling, out, 1, vertical velocity > 0
- facing_left, out, 1, sprite faces left
- scroll_valid, out, 1, one-cycle world-shift request
- scroll_amt, out, Y_W, shift in px, valid with scroll_valid
- dead, out, 1, high in DEAD state
- in_sprite, out, 1, beam inside sprite box
- sprite_u, out, clog2(WIDTH), ROM column
- sprite_v, out, clog2(HEIGHT), ROM row

Function
REQ-003 SHALL implement FSM IDLE -> AIR -> DEAD; all state changes occur only on cycles with frame_tick=1 and run=1.
REQ-004 IDLE: on a step, SHALL go to AIR with vy=-JUMP_V; position unchanged.
REQ-005 AIR step velocity: vy_next = min(vy+GRAVITY, VMAX), signed, saturating; y_fp_next = y_fp + vy (old vy).
REQ-006 Landing: if land_hit and vy>0, SHALL set pos_y=land_y-HEIGHT, frac=0, vy=-JUMP_V; land_hit while vy<=0 SHALL be ignored.
REQ-007 Scroll: if the resulting integer y < SCROLL_LINE, SHALL clamp pos_y to SCROLL_LINE and assert scroll_valid for exactly the next cycle, with scroll_amt=SCROLL_LINE-y; this is evaluated after landing.
REQ-008 Death: if the resulting y >= DEATH_Y and no landing occurred, SHALL enter DEAD; dead=1 until rst; in DEAD, position and velocity hold.
REQ-009 Horizontal, every step in IDLE/AIR: x' = pos_x + delta_x. If x' <= LEFT_B-WIDTH/2, pos_x=RIGHT_B-WIDTH/2-1. Else if x' >= RIGHT_B-WIDTH/2, pos_x=LEFT_B-WIDTH/2+1. Else pos_x=x'.
REQ-010 facing_left SHALL be set by delta_x<0 and cleared by delta_x>0 on each step; it holds when delta_x=0.
REQ-011 falling SHALL equal (vy>0), registered.
REQ-012 run=0 or frame_tick=0: all physics state SHALL hold; scroll_valid=0.
REQ-013 Render path has 1-cycle latency. in_sprite = pos_x<=beam_x<pos_x+WIDTH and pos_y<=beam_y<pos_y+HEIGHT. sprite_v=beam_y-pos_y. sprite_u=beam_x-pos_x, mirrored to WIDTH-1-(beam_x-pos_x) when facing_left. u/v are don't-care when in_sprite=0.
REQ-014 Internal vertical position SHALL be signed Y_W+FRAC+2 bits to absorb transient negative and overflow values before clamping.

Reset
REQ-015 On rst SHALL set: state IDLE, pos_x=START_X, pos_y=START_Y, frac=0, vy=0, facing_left=0, falling=0, scroll_valid=0, scroll_amt=0, dead=0, in_sprite=0.
REQ-016 rst mid-AIR or in DEAD SHALL take effect on the same edge; it overrides frame_tick.

Structure
REQ-017 State enum and fixed-point width helper SHALL live in shared package player_pkg.
REQ-018 Render window (REQ-013) SHALL be sub-module sprite_window, parameterised by WIDTH, HEIGHT, X_W, Y_W.

Verification
REQ-019 rst, then one step with run=1 -> state AIR, vy=-160; next step pos_y=389.
REQ-020 Free fall from vy=0, 40 steps -> vy saturates at 256 and pos_y advances exactly 16 px per step thereafter.
REQ-021 Falling with land_hit=1, land_y=420 -> pos_y=340, vy=-160, falling=0 next cycle; land_hit during rise -> no effect.
REQ-022 Rising from pos_y=205 at vy=-160 -> pos_y=200, scroll_valid one cycle, scroll_amt=5.
REQ-023 pos_x=121 with delta_x=-1 -> pos_x=599; pos_x=599 with delta_x=+1 -> pos_x=121; delta_x=-3 -> facing_left=1, beam at pos_x gives sprite_u=79.
REQ-024 Fall to y>=480 -> dead=1, steps ignored; rst -> IDLE at (280,399).
